// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared bus widths, state encoding and legal access widths for the memory arbiter
package mem_arbiter_pkg;
  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;
  localparam int NUM_REQ_DEF = 4;
  localparam logic [3:0] W_BYTE = 4'd1;
  localparam logic [3:0] W_HALF = 4'd2;
  localparam logic [3:0] W_WORD = 4'd4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;
  function automatic logic width_ok(input logic [3:0] w);
    return w == W_BYTE || w == W_HALF || w == W_WORD;
  endfunction
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: port 0 wins outright, otherwise round-robin over ports 1..NUM_REQ-1 from ptr_i
module arb_rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);
  logic [IW-1:0] p;
  // scanning backwards lets the slot nearest the pointer overwrite the others
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    p = '0;
    for (int i = NUM_REQ - 2; i >= 0; i--) begin
      p = IW'((int'(ptr_i) + i - 1) % (NUM_REQ - 1) + 1);
      if (req_i[p]) idx_o = p;
    end
    if (req_i[0]) idx_o = '0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port among NUM_REQ requesters, one 4-cycle access at a time
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_ce_i,
  input  logic [NUM_REQ-1:0]                req_we_i,
  input  logic [NUM_REQ-1:0][ADDR_BUS-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][3:0]           req_width_i,
  input  logic [NUM_REQ-1:0][DATA_BUS-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                req_ack_o,
  output logic [NUM_REQ-1:0][DATA_BUS-1:0]  req_data_o,
  output logic                              mem_ce_o,
  output logic                              mem_we_o,
  output logic [ADDR_BUS-1:0]               mem_addr_o,
  output logic [3:0]                        mem_width_o,
  output logic [DATA_BUS-1:0]               mem_data_o,
  input  logic [DATA_BUS-1:0]               mem_data_i,
  output logic                              busy_o,
  output logic                              err_o
);
  localparam int IW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [IW-1:0] rr_q, win_q, pick_idx;
  logic pick_v, grant, we_q, bad_q, err_q;
  logic [ADDR_BUS-1:0] addr_q;
  logic [3:0] width_q;
  logic [DATA_BUS-1:0] wdata_q;
  logic [NUM_REQ-1:0][DATA_BUS-1:0] rdata_q;

  arb_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_i  (req_ce_i),
    .ptr_i  (rr_q),
    .valid_o(pick_v),
    .idx_o  (pick_idx)
  );

  assign grant = state_q == IDLE && pick_v;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;

  // an illegal width never strobes memory, so it goes straight to WAIT
  always_comb
    state_d = state_q == IDLE ? (!pick_v ? IDLE : width_ok(req_width_i[pick_idx]) ? ISSUE : WAIT)
            : state_q == ISSUE ? WAIT : state_q == WAIT ? ACK : IDLE;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr_q <= IW'(1);
      win_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      width_q <= '0;
      wdata_q <= '0;
      bad_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (grant) begin
        win_q <= pick_idx;
        we_q <= req_we_i[pick_idx];
        addr_q <= req_addr_i[pick_idx];
        width_q <= req_width_i[pick_idx];
        wdata_q <= req_data_i[pick_idx];
        bad_q <= !width_ok(req_width_i[pick_idx]);
        err_q <= err_q | !width_ok(req_width_i[pick_idx]);
        if (pick_idx != '0) rr_q <= pick_idx == IW'(NUM_REQ - 1) ? IW'(1) : pick_idx + IW'(1);
      end
      if (state_q == WAIT && !we_q && !bad_q) rdata_q[win_q] <= mem_data_i;
    end

  always_comb begin
    busy_o = state_q != IDLE;
    mem_ce_o = state_q == ISSUE;
    mem_we_o = mem_ce_o & we_q;
    mem_addr_o = mem_ce_o ? addr_q : '0;
    mem_width_o = mem_ce_o ? width_q : '0;
    mem_data_o = mem_ce_o ? wdata_q : '0;
    req_ack_o = state_q == ACK ? NUM_REQ'(1) << win_q : '0;
    req_data_o = rdata_q;
    err_o = err_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int NR = 4;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  width;
    logic [31:0] data;
    logic        drop;
  } txn_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [NR-1:0] req_ce_i = '0, req_we_i = '0, req_ack_o;
  logic [NR-1:0][31:0] req_addr_i = '0, req_data_i = '0, req_data_o;
  logic [NR-1:0][3:0] req_width_i = '0;
  logic mem_ce_o, mem_we_o, busy_o, err_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i = '0;
  logic [3:0] mem_width_o;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_ce_i(req_ce_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_width_i(req_width_i), .req_data_i(req_data_i),
    .req_ack_o(req_ack_o), .req_data_o(req_data_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int vecs = 0, errs = 0, cyc = 0;
  txn_t pq[NR][$];
  logic [31:0] mem[logic [31:0]];
  // model: one access in flight, k counts cycles since its grant
  logic m_act, m_we, m_bad, m_err;
  int m_k, m_win, m_rr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0] m_width;
  logic [NR-1:0][31:0] m_data;
  int ack_log[$], ack_cyc[$], strobes, first_busy;
  logic [31:0] st_addr[$], st_data[$];
  logic st_we[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {~a[15:0], a[15:0]};
  endfunction

  function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [3:0] w,
                              input logic [31:0] d, input logic drop);
    txn_t t;
    t.we = we; t.addr = a; t.width = w; t.data = d; t.drop = drop;
    return t;
  endfunction

  function automatic bit pending();
    for (int p = 0; p < NR; p++) if (pq[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_k = 0; m_rr = 1; m_err = 1'b0; m_data = '0; m_bad = 1'b0; m_win = 0;
  endtask

  task automatic clear_logs();
    ack_log.delete(); ack_cyc.delete(); st_addr.delete(); st_data.delete(); st_we.delete();
    strobes = 0; first_busy = -1;
  endtask

  task automatic tick();
    txn_t t;
    int ack_k, w, pp;
    logic e_ce;
    logic [NR-1:0] e_ack;
    @(posedge clk); #1;
    for (int p = 0; p < NR; p++) begin
      if (pq[p].size() == 0) req_ce_i[p] = 1'b0;
      else begin
        t = pq[p][0];
        req_ce_i[p] = !(t.drop && m_act && m_win == p);
        req_we_i[p] = t.we; req_addr_i[p] = t.addr; req_width_i[p] = t.width; req_data_i[p] = t.data;
      end
    end
    @(negedge clk);
    cyc++;
    if (!rst) begin
      vecs++;
      if ({busy_o, err_o, mem_ce_o, mem_we_o, req_ack_o, mem_addr_o, mem_width_o, mem_data_o, req_data_o} !== '0) begin
        errs++; $display("FAIL reset_outputs: busy=%b err=%b ce=%b ack=%b addr=%h required all zero", busy_o, err_o, mem_ce_o, req_ack_o, mem_addr_o);
      end
      model_reset();
      return;
    end
    ack_k = m_bad ? 2 : 3;
    e_ce = m_act && !m_bad && m_k == 1;
    e_ack = '0;
    if (m_act && m_k == ack_k) e_ack[m_win] = 1'b1;
    vecs++; if (busy_o !== m_act) begin errs++; $display("FAIL busy @%0d: got %b want %b", cyc, busy_o, m_act); end
    vecs++; if (mem_ce_o !== e_ce) begin errs++; $display("FAIL mem_ce @%0d: got %b want %b", cyc, mem_ce_o, e_ce); end
    vecs++; if (req_ack_o !== e_ack) begin errs++; $display("FAIL ack @%0d: got %b want %b", cyc, req_ack_o, e_ack); end
    vecs++; if (err_o !== m_err) begin errs++; $display("FAIL err @%0d: got %b want %b", cyc, err_o, m_err); end
    vecs++; if (req_data_o !== m_data) begin errs++; $display("FAIL rdata @%0d: got %h want %h", cyc, req_data_o, m_data); end
    if (e_ce) begin
      vecs++;
      if ({mem_we_o, mem_addr_o, mem_width_o, mem_data_o} !== {m_we, m_addr, m_width, m_wdata}) begin
        errs++; $display("FAIL mem_fields @%0d: got we=%b a=%h w=%h d=%h want we=%b a=%h w=%h d=%h", cyc,
          mem_we_o, mem_addr_o, mem_width_o, mem_data_o, m_we, m_addr, m_width, m_wdata);
      end
    end
    if (busy_o && first_busy < 0) first_busy = cyc;
    if (mem_ce_o) begin strobes++; st_addr.push_back(mem_addr_o); st_data.push_back(mem_data_o); st_we.push_back(mem_we_o); end
    for (int p = 0; p < NR; p++) if (req_ack_o[p]) begin ack_log.push_back(p); ack_cyc.push_back(cyc); end
    // memory side: read data valid for the whole cycle after the strobe, noise otherwise
    if (m_act && !m_bad && m_k == 1) begin
      if (m_we) mem[m_addr] = m_wdata;
      else mem_data_i = mem_rd(m_addr);
    end else if (!(m_act && !m_bad && m_k == 2)) mem_data_i = $urandom;
    if (m_act && m_k == ack_k - 1 && !m_we && !m_bad) m_data[m_win] = mem_rd(m_addr);
    if (m_act) begin
      if (m_k == ack_k) begin m_act = 1'b0; void'(pq[m_win].pop_front()); end
      else m_k++;
    end else if (|req_ce_i) begin
      w = -1;
      if (req_ce_i[0]) w = 0;
      else for (int j = 0; j < NR - 1; j++) begin
        pp = m_rr + j;
        if (pp >= NR) pp -= NR - 1;
        if (w < 0 && req_ce_i[pp]) w = pp;
      end
      m_win = w; m_we = req_we_i[w]; m_addr = req_addr_i[w]; m_width = req_width_i[w]; m_wdata = req_data_i[w];
      m_bad = !(m_width inside {4'd1, 4'd2, 4'd4});
      m_err = m_err | m_bad;
      if (w > 0) m_rr = w == NR - 1 ? 1 : w + 1;
      m_act = 1'b1; m_k = 1;
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((pending() || m_act) && n < budget) begin tick(); n++; end
    vecs++;
    if (n >= budget) begin errs++; $display("FAIL timeout: %0d cycles used, limit %0d", n, budget); end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int p = 0; p < NR; p++) pq[p].delete();
    tick(); tick();
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    #1;
    vecs++;
    if ({busy_o, err_o, mem_ce_o, req_ack_o, req_data_o} !== '0) begin
      errs++; $display("FAIL reset_initial: busy=%b err=%b ce=%b ack=%b required zero", busy_o, err_o, mem_ce_o, req_ack_o);
    end
    tick(); tick(); tick();
    rst = 1'b1;
    clear_logs();
    tick(); tick();
  endtask

  task automatic test_single_read();
    do_reset();
    mem[32'h40] = 32'hDEADBEEF;
    pq[2].push_back(mk(1'b0, 32'h40, 4'd4, 32'h0, 1'b0));
    run(50);
    vecs++; if (ack_log.size() != 1 || ack_log[0] != 2) begin errs++; $display("FAIL single_ack: got %0d acks want one on port 2", ack_log.size()); end
    vecs++; if (strobes != 1) begin errs++; $display("FAIL single_strobes: got %0d want 1", strobes); end
    vecs++; if (ack_cyc.size() != 1 || ack_cyc[0] - first_busy != 2) begin errs++; $display("FAIL single_latency: busy@%0d acks=%0d", first_busy, ack_cyc.size()); end
    vecs++; if (req_data_o[2] !== 32'hDEADBEEF) begin errs++; $display("FAIL single_data: got %h want deadbeef", req_data_o[2]); end
  endtask

  task automatic test_contention();
    int exp_o[6] = '{1, 2, 3, 1, 2, 3};
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 1; p < NR; p++) pq[p].push_back(mk(1'b0, {$urandom_range(0, 255), 2'b00}, 4'd4, $urandom, 1'b0));
    run(100);
    vecs++;
    if (ack_log.size() != 6) begin errs++; $display("FAIL contention_count: got %0d want 6", ack_log.size()); end
    else for (int i = 0; i < 6; i++) begin
      vecs++; if (ack_log[i] != exp_o[i]) begin errs++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, ack_log[i], exp_o[i]); end
      if (i > 0) begin
        vecs++; if (ack_cyc[i] - ack_cyc[i-1] != 4) begin errs++; $display("FAIL contention_gap[%0d]: got %0d want 4", i, ack_cyc[i] - ack_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    pq[1].push_back(mk(1'b0, 32'h20, 4'd2, 32'h0, 1'b0));
    pq[3].push_back(mk(1'b0, 32'h30, 4'd1, 32'h0, 1'b0));
    pq[0].push_back(mk(1'b1, 32'h10, 4'd4, 32'h1234, 1'b0));
    run(100);
    vecs++;
    if (ack_log.size() != 3 || ack_log[0] != 0 || ack_log[1] != 1 || ack_log[2] != 3) begin
      errs++; $display("FAIL priority_order: got %0d acks, first=%0d want 0,1,3", ack_log.size(), ack_log.size() ? ack_log[0] : -1);
    end
    vecs++;
    if (st_addr.size() == 0 || st_we[0] !== 1'b1 || st_addr[0] !== 32'h10 || st_data[0] !== 32'h1234) begin
      errs++; $display("FAIL priority_write: strobes=%0d want first write 1234 to 10", st_addr.size());
    end
  endtask

  task automatic test_illegal();
    do_reset();
    pq[1].push_back(mk(1'b1, 32'h50, 4'd3, 32'hABCD, 1'b0));
    run(50);
    vecs++; if (strobes != 0) begin errs++; $display("FAIL illegal_strobe: got %0d want 0", strobes); end
    vecs++; if (ack_log.size() != 1 || ack_log[0] != 1) begin errs++; $display("FAIL illegal_ack: got %0d acks want one on port 1", ack_log.size()); end
    vecs++; if (err_o !== 1'b1) begin errs++; $display("FAIL illegal_err: got %b want 1", err_o); end
    pq[2].push_back(mk(1'b0, 32'h54, 4'd2, 32'h0, 1'b0));
    run(50);
    vecs++; if (err_o !== 1'b1 || strobes != 1) begin errs++; $display("FAIL err_sticky: err=%b strobes=%0d want 1,1", err_o, strobes); end
    do_reset();
    vecs++; if (err_o !== 1'b0) begin errs++; $display("FAIL err_clear: got %b want 0", err_o); end
  endtask

  task automatic test_drop();
    do_reset();
    mem[32'h80] = 32'hCAFEF00D;
    pq[3].push_back(mk(1'b0, 32'h80, 4'd4, 32'h0, 1'b1));
    run(50);
    vecs++; if (ack_log.size() != 1 || ack_log[0] != 3) begin errs++; $display("FAIL drop_ack: got %0d acks want one on port 3", ack_log.size()); end
    vecs++; if (req_data_o[3] !== 32'hCAFEF00D) begin errs++; $display("FAIL drop_data: got %h want cafef00d", req_data_o[3]); end
  endtask

  task automatic test_reset_wait();
    int n = 0;
    do_reset();
    pq[2].push_back(mk(1'b0, 32'h44, 4'd4, 32'h0, 1'b0));
    while (!(m_act && m_k == 2) && n < 10) begin tick(); n++; end
    @(posedge clk); #2;
    vecs++; if (busy_o !== 1'b1 || n >= 10) begin errs++; $display("FAIL rstwait_setup: busy=%b after %0d cycles", busy_o, n); end
    rst = 1'b0;
    #1;
    vecs++;
    if ({busy_o, mem_ce_o, req_ack_o, err_o, req_data_o} !== '0) begin
      errs++; $display("FAIL rstwait_async: busy=%b ce=%b ack=%b required zero", busy_o, mem_ce_o, req_ack_o);
    end
    for (int p = 0; p < NR; p++) pq[p].delete();
    model_reset();
    tick(); tick();
    rst = 1'b1;
    clear_logs();
    pq[3].push_back(mk(1'b0, 32'h60, 4'd4, 32'h0, 1'b0));
    pq[2].push_back(mk(1'b0, 32'h64, 4'd4, 32'h0, 1'b0));
    run(50);
    vecs++;
    if (ack_log.size() != 2 || ack_log[0] != 2 || ack_log[1] != 3) begin
      errs++; $display("FAIL rstwait_resume: got %0d acks, first=%0d want 2,3", ack_log.size(), ack_log.size() ? ack_log[0] : -1);
    end
  endtask

  task automatic test_random();
    int cnt[NR], got[NR], p, ws;
    logic [3:0] w;
    do_reset();
    for (int i = 0; i < NR; i++) begin cnt[i] = 0; got[i] = 0; end
    for (int wave = 0; wave < 2; wave++) begin
      for (int i = 0; i < 40; i++) begin
        p = $urandom_range(0, NR - 1);
        ws = $urandom_range(0, 9);
        w = ws == 0 ? 4'd3 : ws == 1 ? 4'd0 : ws < 5 ? 4'd4 : ws < 8 ? 4'd2 : 4'd1;
        pq[p].push_back(mk(1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, w, $urandom,
                           $urandom_range(0, 3) == 0));
        cnt[p]++;
      end
      run(1000);
    end
    foreach (ack_log[i]) got[ack_log[i]]++;
    for (int i = 0; i < NR; i++) begin
      vecs++; if (got[i] != cnt[i]) begin errs++; $display("FAIL random_acks[%0d]: got %0d want %0d", i, got[i], cnt[i]); end
    end
  endtask

  initial begin
    model_reset();
    clear_logs();
    test_reset();
    test_single_read();
    test_contention();
    test_priority();
    test_illegal();
    test_drop();
    test_reset_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, requester port count (2..8); port 0 is the control-plane writer, ports 1..NUM_REQ-1 are proc pipelines.
REQ-002 Widths: address and data buses SHALL use the shared `ADDR_BUS` / `DATA_BUS` definitions (32 bits each).
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 req_ce_i  in  NUM_REQ  per-port access request; held high until that port's ack.
REQ-006 req_we_i  in  NUM_REQ  per-port write enable; 1 = write, 0 = read.
REQ-007 req_addr_i  in  NUM_REQ x 32  per-port byte address.
REQ-008 req_width_i  in  NUM_REQ x 4  per-port access width in bytes; legal values 1, 2, 4.
REQ-009 req_data_i  in  NUM_REQ x 32  per-port write data.
REQ-010 req_ack_o  out  NUM_REQ  one-cycle completion pulse per port.
REQ-011 req_data_o  out  NUM_REQ x 32  per-port read data; valid with ack, held until that port's next ack.
REQ-012 mem_ce_o, mem_we_o  out  1 each  shared memory strobe and write enable.
REQ-013 mem_addr_o / mem_width_o / mem_data_o  out  32 / 4 / 32  shared memory address, width and write data.
REQ-014 mem_data_i  in  32  memory read data, valid one cycle after mem_ce_o.
REQ-015 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-016 err_o  out  1  sticky flag, set by any granted request with an illegal width.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, ACK; every access SHALL take exactly 4 cycles from grant to the ack cycle inclusive.
REQ-018 IDLE: if any req_ce_i bit is high, select a winner, latch its we/addr/width/data and index, then go to ISSUE; otherwise stay in IDLE.
REQ-019 Selection: port 0 SHALL win whenever its req_ce_i is high; otherwise ports 1..NUM_REQ-1 are served round-robin starting from the rr pointer.
REQ-020 rr pointer: after a grant to port k (k >= 1), the pointer SHALL become k+1, wrapping from NUM_REQ-1 to 1; a grant to port 0 SHALL leave it unchanged.
REQ-021 ISSUE: drive mem_ce_o=1 and mem_we_o/addr/width/data from the latched fields for exactly one cycle, then go to WAIT; outside ISSUE, mem_ce_o SHALL be 0.
REQ-022 WAIT: on a read, capture mem_data_i into req_data_o[winner]; go to ACK.
REQ-023 ACK: assert req_ack_o[winner] for exactly one cycle, then go to IDLE; at most one ack bit SHALL be high in any cycle.
REQ-024 Writes SHALL leave req_data_o[winner] unchanged.
REQ-025 Illegal width (0, 3, 5..15): no memory strobe; skip ISSUE; WAIT and ACK still occur so the requester never hangs; set err_o.
REQ-026 A requester dropping req_ce_i after grant SHALL NOT abort the access; the ack still pulses.
REQ-027 A requester re-raising req_ce_i in the cycle after its ack SHALL be eligible in that IDLE cycle.
REQ-028 Non-granted requests SHALL simply wait; no request is lost or reordered within a port.
REQ-029 Starvation bound: a continuously requesting pipeline port SHALL be granted within NUM_REQ-1 pipeline grants, provided port 0 is idle.

Reset
REQ-030 While rst is 0: state IDLE, rr pointer = 1, all req_ack_o / req_data_o / mem_* / busy_o / err_o = 0; effect is asynchronous.
REQ-031 Reset during ISSUE, WAIT or ACK SHALL abandon the access with no ack; the memory side sees no further strobe.
REQ-032 err_o SHALL clear only on reset.

Structure
REQ-033 A shared package SHALL hold the state enum typedef, the NUM_REQ default and the legal-width constants.
REQ-034 One sub-module, arb_rr_pick, SHALL contain the combinational selection logic (port-0 priority plus round-robin from the pointer); the FSM, latches and data registers stay in mem_arbiter.

Verification
REQ-035 Single read: port 2 reads addr 0x40, width 4, memory returns 0xDEADBEEF -> one mem_ce_o pulse, req_ack_o[2] 4 cycles after grant, req_data_o[2]=0xDEADBEEF.
REQ-036 Contention: ports 1, 2 and 3 request continuously -> grant order 1, 2, 3, 1, 2, 3; one ack every 4 cycles.
REQ-037 Priority: port 0 writes 0x1234 to 0x10 while ports 1 and 3 are pending -> port 0 is granted first and the rr pointer is unchanged; the following grants go to 1, then 3.
REQ-038 Illegal width 3 on port 1 -> no mem_ce_o pulse, req_ack_o[1] pulses, err_o=1 and stays 1 until reset.
REQ-039 Reset asserted in WAIT -> no ack, all outputs 0 immediately; after release, a new request from port 3 is granted normally with the pointer back at 1.
